ahb_lite_slave_mem: RTL

- AHB-Lite responder: word-organised, byte-addressable memory slave for the testbench initiator and sequencer.
- Samples the address phase and completes the data phase with programmable wait states.
- Returns the two-cycle ERROR response for illegal accesses.
- Sits on the AHB_Bus interface as the DUT-side slave, opposite the bench driver.

---
 rtl/ahb_lite_slave_mem_pkg.sv | 48 ++++
 rtl/ahb_lite_slave_mem_if.sv | 30 +++
 rtl/ahb_lite_slave_mem_mem_array.sv | 27 ++
 rtl/ahb_lite_slave_mem.sv | 119 +++++++++++
 4 files changed

// File: rtl/ahb_lite_slave_mem_pkg.sv
// Shared AHB-Lite definitions for the memory slave: transfer encodings,
// response codes, slave FSM states and address-phase decode helpers.
package ahb_lite_defs;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    SIZE_BYTE = 3'd0,
    SIZE_HALF = 3'd1,
    SIZE_WORD = 3'd2
  } hsize_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } slave_state_t;

  // Size/alignment legality only; the range check depends on memory depth.
  function automatic logic access_illegal(logic [2:0] size, logic [1:0] addr_lsb);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return addr_lsb[0];
      SIZE_WORD: return addr_lsb != 2'b00;
      default:   return 1'b1;
    endcase
  endfunction

  // Little-endian byte lanes touched by a legal transfer.
  function automatic logic [3:0] byte_lanes(logic [2:0] size, logic [1:0] addr_lsb);
    case (size)
      SIZE_BYTE: return 4'b0001 << addr_lsb;
      SIZE_HALF: return addr_lsb[1] ? 4'b1100 : 4'b0011;
      default:   return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/ahb_lite_slave_mem_if.sv
// AHB-Lite bus bundle between the bench driver (master) and the memory slave.
interface AHB_Bus #(
  parameter int ADDR_WIDTH = 32
);
  logic                  HSEL;
  logic [ADDR_WIDTH-1:0] HADDR;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [2:0]            HBURST;
  logic [3:0]            HPROT;
  logic [1:0]            HTRANS;
  logic                  HMASTLOCK;
  logic                  HREADY;
  logic [31:0]           HWDATA;
  logic [31:0]           HRDATA;
  logic                  HREADYOUT;
  logic                  HRESP;

  modport master (
    output HSEL, HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK,
           HREADY, HWDATA,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK,
           HREADY, HWDATA,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahb_lite_slave_mem_mem_array.sv
// Word-organised storage with per-byte write enables and an asynchronous
// read port; contents are deliberately not reset.
module ahb_lite_mem_array #(
  parameter int MEM_DEPTH = 1024,
  parameter int IDX_W     = $clog2(MEM_DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [3:0]       be,
  input  logic [IDX_W-1:0] index,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[index][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[index];

endmodule

// File: rtl/ahb_lite_slave_mem.sv
// AHB-Lite memory slave: samples the address phase, inserts programmable
// wait states and answers illegal accesses with the two-cycle ERROR response.
module ahb_lite_slave_mem
  import ahb_lite_defs::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_DEPTH   = 1024,
  parameter int WAIT_STATES = 0
) (
  input logic   HCLK,
  input logic   HRESETn,
  AHB_Bus.slave bus
);

  localparam int                    IDX_W      = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] BYTE_LIMIT = ADDR_WIDTH'(4 * MEM_DEPTH);
  localparam logic [3:0]            WAIT_LOAD  = 4'(WAIT_STATES);

  slave_state_t     state, state_nxt;
  logic [3:0]       wait_cnt, wait_cnt_nxt;
  logic [IDX_W-1:0] ph_index;
  logic [3:0]       ph_be;
  logic             ph_write;

  logic             accept, illegal, sample;
  logic             mem_we;
  logic [31:0]      mem_rdata;
  logic [31:0]      hrdata;
  logic             hreadyout, hresp;
  logic             unused_bus_bits;

  assign unused_bus_bits = ^{bus.HBURST, bus.HPROT, bus.HMASTLOCK};

  assign accept  = bus.HSEL && bus.HREADY &&
                   (bus.HTRANS == HTRANS_NONSEQ || bus.HTRANS == HTRANS_SEQ);
  assign illegal = access_illegal(bus.HSIZE, bus.HADDR[1:0]) || (bus.HADDR >= BYTE_LIMIT);
  // The address phase is only looked at in states that can end a data phase.
  assign sample  = accept && (state == ST_IDLE || state == ST_DATA || state == ST_ERR2);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state    <= ST_IDLE;
      wait_cnt <= 4'd0;
      ph_index <= '0;
      ph_be    <= 4'b0000;
      ph_write <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (sample) begin
        ph_index <= bus.HADDR[IDX_W+1:2];
        ph_be    <= byte_lanes(bus.HSIZE, bus.HADDR[1:0]);
        ph_write <= bus.HWRITE;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    hreadyout    = 1'b1;
    hresp        = HRESP_OKAY;
    hrdata       = 32'h0;
    mem_we       = 1'b0;
    case (state)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        if (state == ST_DATA) begin
          if (ph_write) mem_we = 1'b1;
          else          hrdata = mem_rdata;
        end
        if (state == ST_ERR2) hresp = HRESP_ERROR;
        if (accept) begin
          if (illegal) begin
            state_nxt = ST_ERR1;
          end else if (WAIT_STATES == 0) begin
            state_nxt = ST_DATA;
          end else begin
            state_nxt    = ST_WAIT;
            wait_cnt_nxt = WAIT_LOAD;
          end
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        hreadyout = 1'b0;
        if (wait_cnt <= 4'd1) begin
          state_nxt    = ST_DATA;
          wait_cnt_nxt = 4'd0;
        end else begin
          wait_cnt_nxt = wait_cnt - 4'd1;
        end
      end
      ST_ERR1: begin
        hreadyout = 1'b0;
        hresp     = HRESP_ERROR;
        state_nxt = ST_ERR2;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  ahb_lite_mem_array #(
    .MEM_DEPTH(MEM_DEPTH),
    .IDX_W    (IDX_W)
  ) u_mem (
    .clk  (HCLK),
    .we   (mem_we),
    .be   (ph_be),
    .index(ph_index),
    .wdata(bus.HWDATA),
    .rdata(mem_rdata)
  );

  assign bus.HRDATA    = hrdata;
  assign bus.HREADYOUT = hreadyout;
  assign bus.HRESP     = hresp;

endmodule
